// File: rtl/ysyx_24100006_lsu.sv
// Load/store unit between EXU and the data memory: aligns addresses, builds byte
// masks, issues one-cycle strobes, waits for the response with a timeout, and extends load data.
module ysyx_24100006_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [7:0]  Mem_WMask,
  output logic [31:0] raddr,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wdone,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        op_load;
  logic        op_store;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic [7:0]  cnt;

  logic        req_load;
  logic        req_store;
  logic        req_mem;
  logic        req_misaligned;
  logic [3:0]  req_mask;
  logic [31:0] req_aligned;
  logic [31:0] req_wdata;

  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;
  logic        resp_hit;

  assign in_ready = (state == IDLE);

  // Decode of the incoming request; a store flag wins when both flags are set.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    req_mask       = 4'b1111;
    req_misaligned = 1'b0;
    req_store      = in_is_store;
    req_load       = in_is_load & ~in_is_store;
    req_mem        = req_load | req_store;
    req_aligned    = {in_addr[31:2], 2'b00};
    req_wdata      = in_wdata << {in_addr[1:0], 3'b000};
    case (in_funct3[1:0])
      2'b00: req_mask = 4'b0001 << in_addr[1:0];
      2'b01: begin
        req_mask       = 4'b0011 << in_addr[1:0];
        req_misaligned = in_addr[0];
      end
      default: begin
        req_mask       = 4'b1111;
        req_misaligned = (in_addr[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    rdata_shifted = mem_rdata >> {offset, 3'b000};
    load_ext      = rdata_shifted;
    case (funct3)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_ext = {24'b0, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_ext = {16'b0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
    resp_hit = (op_load & mem_rvalid) | (op_store & mem_wdone);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_load   <= 1'b0;
      op_store  <= 1'b0;
      funct3    <= 3'b000;
      offset    <= 2'b00;
      cnt       <= 8'd0;
      Mem_Read  <= 1'b0;
      Mem_Write <= 1'b0;
      Mem_WMask <= 8'd0;
      raddr     <= 32'd0;
      waddr     <= 32'd0;
      wdata     <= 32'd0;
      out_valid <= 1'b0;
      out_rdata <= 32'd0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_load  <= req_load;
            op_store <= req_store;
            funct3   <= in_funct3;
            offset   <= in_addr[1:0];
            if (!req_mem || req_misaligned) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= req_mem;
              out_rdata <= 32'd0;
            end else begin
              state     <= REQ;
              Mem_Read  <= req_load;
              Mem_Write <= req_store;
              raddr     <= req_load  ? req_aligned : 32'd0;
              waddr     <= req_store ? req_aligned : 32'd0;
              Mem_WMask <= req_store ? {4'b0000, req_mask} : 8'd0;
              wdata     <= req_store ? req_wdata : 32'd0;
            end
          end
        end
        REQ: begin
          Mem_Read  <= 1'b0;
          Mem_Write <= 1'b0;
          cnt       <= 8'd0;
          state     <= WAIT;
        end
        WAIT: begin
          // A response arriving in the limit cycle still completes normally.
          if (resp_hit) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= op_load ? load_ext : 32'd0;
          end else if (cnt == LAST_CNT) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Directed bench for ysyx_24100006_lsu: a vector table of single transactions plus
// hand sequences for timeout, back-pressure and reset during an outstanding access.
module tb_ysyx_24100006_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [7:0]  Mem_WMask;
  logic [31:0] raddr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_wdone = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rdata;
  logic        out_err;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_24100006_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_load (in_is_load),
    .in_is_store(in_is_store),
    .in_funct3  (in_funct3),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .Mem_Read   (Mem_Read),
    .Mem_Write  (Mem_Write),
    .Mem_WMask  (Mem_WMask),
    .raddr      (raddr),
    .waddr      (waddr),
    .wdata      (wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_wdone  (mem_wdone),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rdata  (out_rdata),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic [7:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
    int          e_nrd;
    int          e_nwr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < 10 && !in_ready; i++) step();
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_addr     = a;
    in_wdata    = wd;
    step();
    in_valid    = 1'b0;
  endtask

  // Cycle 1 is the one right after the accept edge; the response is driven in cycle resp_cyc.
  task automatic wait_done(input int resp_cyc, input logic rv, input logic wd,
                           input logic [31:0] rdat, output int lat, output int nrd, output int nwr);
    lat = 1;
    nrd = 0;
    nwr = 0;
    while (!out_valid && lat < 40) begin
      if (Mem_Read)  nrd++;
      if (Mem_Write) nwr++;
      mem_rvalid = (lat == resp_cyc) & rv;
      mem_wdone  = (lat == resp_cyc) & wd;
      mem_rdata  = rdat;
      step();
      lat++;
    end
    mem_rvalid = 1'b0;
    mem_wdone  = 1'b0;
    check("bounded_wait_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, nrd, nwr;
    string tag;
    tag = $sformatf("vec%0d", idx);
    issue(v.ld, v.st, v.f3, v.addr, v.wd);
    wait_done(2, v.ld & ~v.st, v.st, v.rd, lat, nrd, nwr);
    check({tag, "_latency"}, lat, v.e_lat);
    check({tag, "_nread"}, nrd, v.e_nrd);
    check({tag, "_nwrite"}, nwr, v.e_nwr);
    check({tag, "_rdata"}, out_rdata, v.e_rdata);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, v.e_err});
    if (v.e_nrd != 0) check({tag, "_raddr"}, raddr, v.e_addr);
    if (v.e_nwr != 0) begin
      check({tag, "_waddr"}, waddr, v.e_addr);
      check({tag, "_wmask"}, {24'd0, Mem_WMask}, {24'd0, v.e_mask});
      check({tag, "_wdata"}, wdata, v.e_wdata);
    end
    step();
    check({tag, "_valid_cleared"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nrd, nwr;

    //            ld st f3      addr          wd            rd            e_addr        mask   e_wdata       e_rdata       err lat rd wr
    vecs[0]  = '{1, 0, 3'b000, 32'h80000003, 32'h00000000, 32'h80FF7F01, 32'h80000000, 8'h00, 32'h00000000, 32'hFFFFFF80, 0, 3, 1, 0};
    vecs[1]  = '{1, 0, 3'b100, 32'h80000003, 32'h00000000, 32'h80FF7F01, 32'h80000000, 8'h00, 32'h00000000, 32'h00000080, 0, 3, 1, 0};
    vecs[2]  = '{0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 32'h00000000, 32'h80000000, 8'h0C, 32'hBEEF0000, 32'h00000000, 0, 3, 0, 1};
    vecs[3]  = '{1, 0, 3'b010, 32'h80000001, 32'h00000000, 32'h12345678, 32'h00000000, 8'h00, 32'h00000000, 32'h00000000, 1, 1, 0, 0};
    vecs[4]  = '{1, 0, 3'b001, 32'h80000000, 32'h00000000, 32'h12348765, 32'h80000000, 8'h00, 32'h00000000, 32'hFFFF8765, 0, 3, 1, 0};
    vecs[5]  = '{1, 0, 3'b101, 32'h80000002, 32'h00000000, 32'h8001ABCD, 32'h80000000, 8'h00, 32'h00000000, 32'h00008001, 0, 3, 1, 0};
    vecs[6]  = '{1, 0, 3'b010, 32'h80000004, 32'h00000000, 32'hDEADBEEF, 32'h80000004, 8'h00, 32'h00000000, 32'hDEADBEEF, 0, 3, 1, 0};
    vecs[7]  = '{0, 1, 3'b000, 32'h80000001, 32'h000000A5, 32'h00000000, 32'h80000000, 8'h02, 32'h0000A500, 32'h00000000, 0, 3, 0, 1};
    vecs[8]  = '{0, 1, 3'b010, 32'h80000008, 32'h11223344, 32'h00000000, 32'h80000008, 8'h0F, 32'h11223344, 32'h00000000, 0, 3, 0, 1};
    vecs[9]  = '{0, 0, 3'b000, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 8'h00, 32'h00000000, 32'h00000000, 0, 1, 0, 0};
    vecs[10] = '{0, 1, 3'b001, 32'h80000003, 32'h0000BEEF, 32'h00000000, 32'h00000000, 8'h00, 32'h00000000, 32'h00000000, 1, 1, 0, 0};
    vecs[11] = '{1, 0, 3'b000, 32'h80000001, 32'h00000000, 32'h80FF7F01, 32'h80000000, 8'h00, 32'h00000000, 32'h0000007F, 0, 3, 1, 0};
    vecs[12] = '{1, 1, 3'b010, 32'h8000000C, 32'hCAFEBABE, 32'h00000000, 32'h8000000C, 8'h0F, 32'hCAFEBABE, 32'h00000000, 0, 3, 0, 1};

    step();
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mem_read", {31'd0, Mem_Read}, 32'd0);
    check("rst_mem_write", {31'd0, Mem_Write}, 32'd0);
    check("rst_wmask", {24'd0, Mem_WMask}, 32'd0);
    check("rst_raddr", raddr, 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // No response at all; a wrong-type ack in cycle 3 must be ignored.
    issue(1'b1, 1'b0, 3'b010, 32'h80000010, 32'd0);
    wait_done(3, 1'b0, 1'b1, 32'h5555AAAA, lat, nrd, nwr);
    check("timeout_latency", lat, 6);
    check("timeout_nread", nrd, 1);
    check("timeout_err", {31'd0, out_err}, 32'd1);
    check("timeout_rdata", out_rdata, 32'd0);
    step();

    // Response arrives in the fourth WAIT cycle, the same cycle as the limit.
    issue(1'b1, 1'b0, 3'b010, 32'h80000010, 32'd0);
    wait_done(5, 1'b1, 1'b0, 32'hA5A5A5A5, lat, nrd, nwr);
    check("limit_resp_latency", lat, 6);
    check("limit_resp_err", {31'd0, out_err}, 32'd0);
    check("limit_resp_rdata", out_rdata, 32'hA5A5A5A5);
    step();

    // Back-pressure from WBU: result must be held until the handshake.
    out_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b001, 32'h80000002, 32'd0);
    wait_done(2, 1'b1, 1'b0, 32'h80011234, lat, nrd, nwr);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_out_rdata", out_rdata, 32'hFFFF8001);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    check("hold_in_ready_at_exit", {31'd0, in_ready}, 32'd0);
    step();
    check("hold_released_valid", {31'd0, out_valid}, 32'd0);
    check("hold_released_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while a load is waiting; the late response must not produce a result.
    issue(1'b1, 1'b0, 3'b010, 32'h80000020, 32'd0);
    step();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_raddr", raddr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_mem_read", {31'd0, Mem_Read}, 32'd0);
      check("rst_mid_out_rdata", out_rdata, 32'd0);
    end
    mem_rvalid = 1'b0;
    step();

    run_vec(0, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_lsu.md
Name: ysyx_24100006_lsu

Overview:
Load/store unit sitting directly upstream of the DPI-C data memory stage; consumes memory ops from EXU over a valid/ready handshake. Word-aligns addresses, builds byte write masks, shifts store data, and drives one-cycle read/write strobes. Waits for the memory response with a timeout, then returns sign/zero-extended load data to WBU. Misaligned and timed-out accesses complete with an error flag.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in WAIT before forcing error completion (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  EXU request valid
in_ready  out  1  LSU can accept request
in_is_load  in  1  op is load
in_is_store  in  1  op is store (both low = non-memory op; both high treated as store)
in_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  in  32  byte address
in_wdata  in  32  store data, LSB-justified
Mem_Read  out  1  read strobe to memory
Mem_Write  out  1  write strobe to memory
Mem_WMask  out  8  byte enables; [3:0] used, [7:4] always 0
raddr  out  32  word-aligned read address
waddr  out  32  word-aligned write address
wdata  out  32  lane-shifted store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
mem_wdone  in  1  write acknowledged
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts result
out_rdata  out  32  extended load data (0 for stores/non-mem/errors)
out_err  out  1  misaligned or timeout

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (async, any state) -> IDLE; all outputs 0; timeout counter 0.
- in_ready = 1 only in IDLE. Request latched on rising edge with in_valid & in_ready.
- Accept: misaligned (H with addr[0]=1, W with addr[1:0]!=0) or non-memory op -> DONE directly; misaligned sets out_err=1; no strobe ever issued.
- Otherwise -> REQ. In REQ, for exactly one cycle: Mem_Read (load) or Mem_Write (store) =1; raddr/waddr = {addr[31:2],2'b00}; REQ -> WAIT unconditionally.
- Store mask: B 4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111; wdata = in_wdata << (8*addr[1:0]). Mask/data/addresses held stable from REQ until DONE exits; strobes low outside REQ.
- WAIT: load completes on mem_rvalid, store on mem_wdone; wrong-type response ignored. Responses are sampled only in WAIT (memory minimum latency 1 cycle); responses in IDLE/REQ/DONE ignored.
- Timeout: counter clears on entry to WAIT, increments each WAIT cycle without a response; when count reaches TIMEOUT_CYCLES -> DONE with out_err=1, out_rdata=0. A response in the same cycle as the limit wins (normal completion).
- Load extraction: byte = mem_rdata >> 8*addr[1:0]; B/H sign-extend bit 7/15, BU/HU zero-extend, W unchanged. Registered into out_rdata on WAIT -> DONE.
- DONE: out_valid=1, out_rdata/out_err stable until out_valid & out_ready; then -> IDLE, out_valid=0. No new request accepted in the same cycle as DONE exit (in_ready rises the next cycle).
- Latency (1-cycle memory, out_ready=1): accept cycle 0, strobe cycle 1, response cycle 2, out_valid cycle 3, in_ready cycle 4. Misaligned/non-mem: out_valid cycle 1.
- Reset mid-transaction: outstanding response afterwards ignored; no strobe re-issued.

Test Plan:
- LB addr 0x80000003, mem_rdata 0x80FF7F01 next cycle -> raddr 0x80000000, one-cycle Mem_Read, out_rdata 0xFFFFFF80, out_err 0; LBU same -> 0x00000080.
- SH addr 0x80000002, in_wdata 0x0000BEEF -> waddr 0x80000000, wdata 0xBEEF0000, Mem_WMask 8'b00001100, Mem_Write high exactly 1 cycle; mem_wdone -> out_valid, out_rdata 0.
- LW addr 0x80000001 -> no Mem_Read ever, out_valid next cycle, out_err 1, out_rdata 0.
- TIMEOUT_CYCLES=4, load with no mem_rvalid -> out_valid after 4 WAIT cycles with out_err 1; repeat with mem_rvalid in 4th WAIT cycle -> normal data, err 0.
- LH addr 0x80000002, mem_rdata 0x8001xxxx, out_ready low 5 cycles -> out_valid/out_rdata 0xFFFF8001 held 5 cycles, in_ready low until after handshake.
- rst pulsed during WAIT, then mem_rvalid -> outputs 0, state IDLE, in_ready 1, no out_valid.
